// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: start/stop, lap freeze, long-press clear and a small
// lap memory that can be browsed while stopped.
//
// state      | meaning
// S_STOP     | counter halted, display shows elapsed
// S_RUN      | counter running, display shows elapsed
// S_RUN_FRZ  | counter running, display frozen at lap value
// S_STOP_FRZ | counter halted, display frozen at lap value
// S_RECALL   | counter halted, display shows lap memory entry ptr
module stopwatch_lap_ctrl #(
    parameter int CNT_W     = 16,
    parameter int LAP_DEPTH = 4,
    parameter int LAP_AW    = 2,
    parameter int HOLD_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              in_stop,
    input  logic              in_lap,
    input  logic              in_lap_level,
    input  logic              in_recall,
    output logic [CNT_W-1:0]  time_out,
    output logic              count_en,
    output logic              freeze_en,
    output logic              recall_en,
    output logic              count_reset,
    output logic [LAP_AW:0]   lap_cnt,
    output logic              lap_full,
    output logic              ovf
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        S_STOP, S_RUN, S_RUN_FRZ, S_STOP_FRZ, S_RECALL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    elapsed_q, elapsed_d;
    logic [CNT_W-1:0]    frz_q, frz_d;
    logic [LAP_AW-1:0]   ptr_q, ptr_d;
    logic [LAP_AW:0]     lap_cnt_q, lap_cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                ovf_q, ovf_d;
    logic                cr_q, cr_d;
    logic                push;
    logic                clear;
    logic                running;
    logic                full;
    logic [CNT_W-1:0]    mem_q [LAP_DEPTH];

    assign full    = (lap_cnt_q == (LAP_AW+1)'(LAP_DEPTH));
    assign running = (state_q == S_RUN) || (state_q == S_RUN_FRZ);
    // Fires only on the transition into saturation, so a held button clears once.
    assign clear   = in_lap_level && (hold_q == HOLD_W'(HOLD_CYC - 1));

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        frz_d     = frz_q;
        ptr_d     = ptr_q;
        lap_cnt_d = lap_cnt_q;
        ovf_d     = ovf_q;
        cr_d      = 1'b0;
        push      = 1'b0;
        hold_d    = hold_q;

        if (!in_lap_level)
            hold_d = '0;
        else if (hold_q < HOLD_W'(HOLD_CYC))
            hold_d = hold_q + HOLD_W'(1);

        if (clear) begin
            state_d   = S_STOP;
            elapsed_d = '0;
            frz_d     = '0;
            ptr_d     = '0;
            lap_cnt_d = '0;
            ovf_d     = 1'b0;
            cr_d      = 1'b1;
        end else begin
            if (running && tick) begin
                if (elapsed_q == '1) ovf_d = 1'b1;
                else                 elapsed_d = elapsed_q + CNT_W'(1);
            end

            if (in_stop) begin
                case (state_q)
                    S_STOP:     state_d = S_RUN;
                    S_RUN:      state_d = S_STOP;
                    S_RUN_FRZ:  state_d = S_STOP_FRZ;
                    S_STOP_FRZ: state_d = S_RUN_FRZ;
                    S_RECALL:   state_d = S_RUN;
                    default:    state_d = S_STOP;
                endcase
            end else if (in_lap) begin
                case (state_q)
                    S_RUN: begin
                        state_d = S_RUN_FRZ;
                        frz_d   = elapsed_q;
                        if (!full) begin
                            push      = 1'b1;
                            lap_cnt_d = lap_cnt_q + (LAP_AW+1)'(1);
                        end
                    end
                    S_RUN_FRZ:  state_d = S_RUN;
                    S_STOP: begin
                        state_d = S_STOP_FRZ;
                        frz_d   = elapsed_q;
                    end
                    S_STOP_FRZ: state_d = S_STOP;
                    default:    state_d = state_q;
                endcase
            end else if (in_recall) begin
                if (state_q == S_STOP && lap_cnt_q != '0) begin
                    state_d = S_RECALL;
                    ptr_d   = '0;
                end else if (state_q == S_RECALL) begin
                    if (({1'b0, ptr_q} + (LAP_AW+1)'(1)) < lap_cnt_q)
                        ptr_d = ptr_q + LAP_AW'(1);
                    else
                        state_d = S_STOP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_STOP;
            elapsed_q <= '0;
            frz_q     <= '0;
            ptr_q     <= '0;
            lap_cnt_q <= '0;
            hold_q    <= '0;
            ovf_q     <= 1'b0;
            cr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            frz_q     <= frz_d;
            ptr_q     <= ptr_d;
            lap_cnt_q <= lap_cnt_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
            cr_q      <= cr_d;
        end
    end

    // Lap storage is masked by lap_cnt, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[lap_cnt_q[LAP_AW-1:0]] <= elapsed_q;
    end

    assign count_en    = running;
    assign freeze_en   = (state_q == S_RUN_FRZ) || (state_q == S_STOP_FRZ);
    assign recall_en   = (state_q == S_RECALL);
    assign count_reset = cr_q;
    assign lap_cnt     = lap_cnt_q;
    assign lap_full    = full;
    assign ovf         = ovf_q;
    assign time_out    = recall_en ? mem_q[ptr_q] : (freeze_en ? frz_q : elapsed_q);

endmodule
